aes_inv_sub_bytes: RTL and testbench
====================================

# aes_inv_sub_bytes

Sequential InvSubBytes engine for the AES decipher datapath. It accepts a 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to every byte, BYTES_PER_CYCLE bytes per clock. It returns the result over a second valid/ready handshake. It is the decryption counterpart of the cipher's forward SubBytes stage and sits between InvShiftRows and AddRoundKey in the inverse round.

## Interface
- BYTES_PER_CYCLE, default 4: inverse S-box lookups per clock. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state.
- in_state  input  128  ciphertext-side state. Byte i = bits [127-8i -: 8]; byte 0 is the MSB byte.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  inverse-substituted state, same byte ordering as in_state.

## Operation
- N = 16 / BYTES_PER_CYCLE processing cycles per block.
- FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - in_ready = 1 and out_valid = 0.
  - When in_valid is 1: capture in_state into the working register, clear the byte counter, go to BUSY.
- **BUSY**
  - in_ready = 0 and out_valid = 0.
  - Each cycle, replace bytes cnt*B .. cnt*B+B-1 of the working register with InvSbox(byte), where B = BYTES_PER_CYCLE. Then increment cnt.
  - After the cycle with cnt = N-1, go to DONE.
- **DONE**
  - out_valid = 1 and in_ready = 0. out_state equals the working register and stays stable.
  - When out_ready is 1: go to IDLE. The next block cannot be accepted until the following cycle, so there is no overlap.
- **Inverse S-box**
  - Full 256-entry FIPS-197 inverse table, held internally. It is total, so no X or default output is ever produced.
  - Anchor entries: InvSbox(63)=00, (7c)=01, (00)=52, (52)=48, (ed)=53, (16)=ff.
- **Counter**
  - Width is ceil(log2(N)), minimum 1 bit.
  - For N = 1, BUSY lasts exactly one cycle.
- in_valid and out_ready are ignored in states where they have no effect.
- in_state is sampled only on the accepting edge. Later changes to in_state do not affect the block in flight.
- out_ready may be held high permanently. DONE then lasts exactly one cycle.

## Timing
- **Reset values:** FSM = IDLE, out_valid = 0, out_state = 128'h0, counter = 0.
  - in_ready is forced to 0 while rst is asserted.
  - in_ready rises to 1 in the first cycle after rst deasserts.
- **Reset mid-operation:** rst asserted in BUSY or DONE aborts the block immediately and asynchronously. No partial result is ever presented.
- **Latency:**
  - Input accepted at edge k.
  - out_valid rises after edge k+N: 4 cycles for the default B, 16 cycles for B = 1.
- **Throughput:** with out_ready held at 1, one block per N+2 cycles.
- **Registered outputs:** out_valid and out_state come directly from flops. in_ready is decoded from FSM state and rst only, with no combinational path from any input.
- **Handshakes:**
  - A transfer occurs on any edge where valid and ready are both 1.
  - out_valid, once high, stays high and out_state stays stable until the transfer.

## Test plan
- **Basic vector:** reset, then in_state = 16 bytes of 0x63 with out_ready = 1.
  - out_state = 128'h0.
  - out_valid rises 4 cycles after acceptance and stays high for exactly 1 cycle.
- **Row-0 vector:** in_state = 00 01 02 … 0f.
  - out_state = 52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb.
  - Repeat with BYTES_PER_CYCLE = 1, 2, 8 and 16: identical result, with latency 16, 8, 2 and 1 cycles respectively.
- **Exhaustive table:** 16 blocks covering bytes 00..ff. Every output byte matches the FIPS-197 inverse table, including ed→53 and 16→ff.
- **Backpressure:** out_ready = 0 for 10 cycles after out_valid rises.
  - out_valid and out_state hold stable.
  - in_ready stays 0 and an in_valid pulse is not accepted.
  - Releasing out_ready returns the FSM to IDLE; in_ready = 1 on the next cycle.
- **Input change and abort:**
  - Change in_state during BUSY: the result reflects only the captured value.
  - Assert rst at BUSY cycle 2: out_valid = 0 and out_state = 0 immediately. After release, a new block completes correctly.

Source files
------------

// File: rtl/aes_inv_sub_bytes_if.sv
// Handshake bundle for the InvSubBytes engine: state in, inverse-substituted state out.
// The slave modport is the engine side and the master modport is the upstream/downstream side.
interface aes_inv_sub_bytes_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state
   );
endinterface

// File: rtl/aes_inv_sub_bytes.sv
// Sequential AES InvSubBytes: captures a 128-bit state, applies the FIPS-197 inverse
// S-box BYTES_PER_CYCLE bytes per clock, then holds the result until it is taken.
module aes_inv_sub_bytes #(
   parameter int unsigned BYTES_PER_CYCLE = 4
) (
   input  logic                clk,
   input  logic                rst,
   aes_inv_sub_bytes_if.slave  bus
);

   localparam int unsigned N  = 16 / BYTES_PER_CYCLE;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("aes_inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Entry b occupies bits [2047-8b -: 8]; row r holds entries 16r..16r+15.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[{~b, 3'b111} -: 8];
   endfunction

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [127:0]    work_q, work_d;
   logic            out_valid_q, out_valid_d;
   logic [3:0]      idx;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      out_valid_d = out_valid_q;
      idx         = '0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.in_state;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Byte i sits at bits [127-8i -: 8], i.e. MSB index {~i, 3'b111}.
            for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
               idx = 4'(32'(cnt_q) * BYTES_PER_CYCLE + j);
               work_d[{~idx, 3'b111} -: 8] = inv_sbox(work_q[{~idx, 3'b111} -: 8]);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               cnt_d       = '0;
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = work_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Scoreboard bench for aes_inv_sub_bytes: the driver queues expected results, a
// negedge monitor checks every output transfer; extra instances cover other widths.
module tb_aes_inv_sub_bytes;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rst_v = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int passes = 0;
   int unsigned acc_cyc = 0;
   logic [127:0] exp_q[$];
   logic [3:0] vdone = '0;

   localparam logic [127:0] ROW0_IN = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ROWS [16] = '{
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   aes_inv_sub_bytes_if bus ();

   aes_inv_sub_bytes #(.BYTES_PER_CYCLE(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Present d until accepted; optionally queue the result the monitor must see.
   task automatic send(input logic [127:0] d, input logic [127:0] e, input bit push);
      int unsigned n = 0;
      if (push) exp_q.push_back(e);
      bus.in_state = d;
      bus.in_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
      chk("in_accept", 128'(bus.in_ready), 128'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("drain", 128'(exp_q.size()), 128'd0);
      @(posedge clk); #1;
   endtask

   // Monitor: latency at rise, data at transfer, single-cycle DONE after transfer.
   bit ov_prev   = 1'b0;
   bit post_xfer = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         ov_prev   = 1'b0;
         post_xfer = 1'b0;
      end else begin
         if (post_xfer) begin
            chk("done_one_cycle", 128'(bus.out_valid), 128'd0);
            chk("idle_ready", 128'(bus.in_ready), 128'd1);
            post_xfer = 1'b0;
         end
         if (bus.out_valid && !ov_prev)
            chk("latency", 128'(cyc - acc_cyc), 128'd4);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_output: got %h expected no output", bus.out_state);
            end else begin
               chk("out_state", bus.out_state, exp_q.pop_front());
            end
            post_xfer = 1'b1;
         end
         ov_prev = bus.out_valid;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_var
      localparam int unsigned BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      aes_inv_sub_bytes_if vif ();
      aes_inv_sub_bytes #(.BYTES_PER_CYCLE(BPC)) u_dut_v (
         .clk (clk),
         .rst (rst_v),
         .bus (vif)
      );
      initial begin
         int unsigned n;
         int unsigned acc;
         vif.in_valid  = 1'b0;
         vif.in_state  = '0;
         vif.out_ready = 1'b1;
         wait (rst_v == 1'b0);
         @(posedge clk); #1;
         vif.in_state = ROW0_IN;
         vif.in_valid = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!vif.in_ready && n < 10);
         chk("var_accept", 128'(vif.in_ready), 128'd1);
         @(posedge clk); #1;
         vif.in_valid = 1'b0;
         vif.in_state = '1;
         acc = cyc;
         n = 0;
         do begin @(negedge clk); n++; end while (!vif.out_valid && n < 40);
         chk($sformatf("var_latency_b%0d", BPC), 128'(cyc - acc), 128'(16 / BPC));
         chk($sformatf("var_state_b%0d", BPC), vif.out_state, ROWS[0]);
         @(negedge clk);
         chk($sformatf("var_one_cycle_b%0d", BPC), 128'(vif.out_valid), 128'd0);
         vdone[g] = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] d;
      int unsigned prev;
      int unsigned n;
      bus.in_valid  = 1'b0;
      bus.in_state  = '0;
      bus.out_ready = 1'b1;

      @(negedge clk);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_out_state", bus.out_state, 128'd0);
      @(posedge clk); #1;
      rst   = 1'b0;
      rst_v = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 128'(bus.in_ready), 128'd1);
      @(posedge clk); #1;

      send({16{8'h63}}, 128'h0, 1'b1);

      prev = 0;
      for (int k = 0; k < 16; k++) begin
         for (int b = 0; b < 16; b++) d[127 - 8*b -: 8] = 8'(16*k + b);
         send(d, ROWS[k], 1'b1);
         if (k > 0) chk("throughput", 128'(acc_cyc - prev), 128'd6);
         prev = acc_cyc;
      end
      drain();

      // Backpressure: result must hold and a stray in_valid must be ignored.
      bus.out_ready = 1'b0;
      send({16{8'h00}}, {16{8'h52}}, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.out_valid && n < 50);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_valid", 128'(bus.out_valid), 128'd1);
         chk("bp_state", bus.out_state, {16{8'h52}});
         chk("bp_ready", 128'(bus.in_ready), 128'd0);
         @(posedge clk); #1;
         bus.in_valid = (i >= 2 && i < 5);
         bus.in_state = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      send(128'h637c0052_ed16637c_0052ed16_637c0052,
           128'h00015248_53ff0001_524853ff_00015248, 1'b1);
      bus.in_state = '1;
      repeat (2) @(posedge clk);
      #1 bus.in_state = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      drain();

      // Abort in the middle of BUSY; the block must never emerge.
      send(ROW0_IN, 128'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
      chk("abort_out_state", bus.out_state, 128'd0);
      chk("abort_in_ready", 128'(bus.in_ready), 128'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      send(128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff, ROWS[15], 1'b1);
      drain();

      n = 0;
      while (vdone != 4'hf && n < 100) begin @(negedge clk); n++; end
      chk("variants_done", 128'(vdone), 128'hf);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
